// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/decoder and one SRAM slave.
// Clock and reset stay outside the bundle.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        HREADYOUT;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HRDATA, HRESP, HREADYOUT
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HRDATA, HRESP, HREADYOUT
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised little-endian memory with byte-lane
// writes, programmable wait states and a two-cycle ERROR response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_READY | HREADYOUT=1, HRESP=OKAY; ends an OKAY data phase or idles
// ST_WAIT  | HREADYOUT=0, wait down-counter running
// ST_ERR1  | HREADYOUT=0, HRESP=ERROR (first error cycle)
// ST_ERR2  | HREADYOUT=1, HRESP=ERROR (second error cycle)
module ahb_sram_slave #(
    parameter int  DEPTH       = 512,
    parameter int  WAIT_STATES = 0,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic            HCLK,
    input  logic            HRESET_n,
    ahb_sram_slave_if.slave bus
);

    typedef enum logic [1:0] {ST_READY, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            accept;
    logic            addr_err;
    logic [3:0]      strb;
    logic [AW-1:0]   a_word;
    logic            hreadyout;

    logic            p_valid;
    logic            p_write;
    logic            p_err;
    logic [AW-1:0]   p_addr;
    logic [3:0]      p_strb;

    logic [31:0]     mem [DEPTH];
    logic            wr_commit;
    logic            rd_load;
    logic [AW-1:0]   rd_addr;
    logic [31:0]     rd_merged;
    logic [31:0]     hrdata_q;
    logic            unused_bits;

    assign accept      = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
    assign a_word      = bus.HADDR[AW+1:2];
    assign unused_bits = ^{bus.HBURST, bus.HTRANS[0]};

    // Decode lane strobes and legality of the offered address phase.
    always_comb begin
        addr_err = 1'b0;
        strb     = 4'b0000;
        case (bus.HSIZE)
            3'd0: strb = 4'b0001 << bus.HADDR[1:0];
            3'd1: begin
                strb     = bus.HADDR[1] ? 4'b1100 : 4'b0011;
                addr_err = bus.HADDR[0];
            end
            3'd2: begin
                strb     = 4'b1111;
                addr_err = |bus.HADDR[1:0];
            end
            default: addr_err = 1'b1;
        endcase
        if ((bus.HADDR >> (AW + 2)) != 32'd0) addr_err = 1'b1;
    end

    // State and wait-counter registers.
    always_ff @(posedge HCLK) begin
        if (!HRESET_n) begin
            state_q <= ST_READY;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: ERR2 behaves like READY for accepting the next transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_READY, ST_ERR2: begin
                state_d = ST_READY;
                if (accept) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_CNT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) state_d = ST_READY;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_READY;
        endcase
    end

    assign hreadyout     = (state_q == ST_READY) || (state_q == ST_ERR2);
    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    assign bus.HRDATA    = hrdata_q;

    // Capture the address phase; only advance when the current data phase ends.
    always_ff @(posedge HCLK) begin
        if (!HRESET_n) begin
            p_valid <= 1'b0;
            p_write <= 1'b0;
            p_err   <= 1'b0;
            p_addr  <= '0;
            p_strb  <= 4'b0000;
        end else if (hreadyout) begin
            p_valid <= accept;
            if (accept) begin
                p_write <= bus.HWRITE;
                p_err   <= addr_err;
                p_addr  <= a_word;
                p_strb  <= strb;
            end
        end
    end

    assign wr_commit = (state_q == ST_READY) && p_valid && p_write && !p_err;

    // Byte-lane write on the edge that closes the write data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET_n && wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (p_strb[i]) mem[p_addr][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    // With no wait states the read is fetched at the address edge, so a write
    // committing on that same edge must be merged in lane by lane.
    assign rd_addr = (WAIT_STATES == 0) ? a_word : p_addr;
    assign rd_load = (WAIT_STATES == 0)
                   ? (accept && hreadyout && !addr_err && !bus.HWRITE)
                   : ((state_q == ST_WAIT) && (cnt_q == 4'd1) && p_valid && !p_write);

    // Read word with write-to-read bypass.
    always_comb begin
        rd_merged = mem[rd_addr];
        if (wr_commit && (p_addr == rd_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (p_strb[i]) rd_merged[8*i +: 8] = bus.HWDATA[8*i +: 8];
            end
        end
    end

    // Read data register; holds between reads.
    always_ff @(posedge HCLK) begin
        if (!HRESET_n)    hrdata_q <= 32'd0;
        else if (rd_load) hrdata_q <= rd_merged;
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two slaves (0 and 2 wait states) on one bus,
// scoreboard of expected data-phase responses.
module tb_ahb_sram_slave;
    localparam int DEPTH = 16;

    logic HCLK = 1'b0;
    logic HRESET_n = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus2 ();

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESET_n(HRESET_n), .bus(bus0));
    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut2 (
        .HCLK(HCLK), .HRESET_n(HRESET_n), .bus(bus2));

    bit          dsel = 1'b0;
    logic [1:0]  b_trans = 2'b00;
    logic [31:0] b_addr = 32'd0;
    logic        b_write = 1'b0;
    logic [2:0]  b_size = 3'd2;
    logic [31:0] b_wdata = 32'd0;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic [1:0]  m_resp;

    assign m_ready = dsel ? bus2.HREADYOUT : bus0.HREADYOUT;
    assign m_rdata = dsel ? bus2.HRDATA    : bus0.HRDATA;
    assign m_resp  = dsel ? bus2.HRESP     : bus0.HRESP;

    assign bus0.HSEL = !dsel;       assign bus2.HSEL = dsel;
    assign bus0.HADDR = b_addr;     assign bus2.HADDR = b_addr;
    assign bus0.HTRANS = b_trans;   assign bus2.HTRANS = b_trans;
    assign bus0.HWRITE = b_write;   assign bus2.HWRITE = b_write;
    assign bus0.HSIZE = b_size;     assign bus2.HSIZE = b_size;
    assign bus0.HBURST = 3'd0;      assign bus2.HBURST = 3'd0;
    assign bus0.HWDATA = b_wdata;   assign bus2.HWDATA = b_wdata;
    assign bus0.HREADY = m_ready;   assign bus2.HREADY = m_ready;

    typedef struct {
        logic [1:0]  resp;
        int          waits;
        bit          rd;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } sb_t;

    sb_t         sbq[$];
    logic [31:0] mm [2][DEPTH];
    logic [31:0] m_hrdata [2];
    int          n_err = 0;
    int          n_chk = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [2:0] sz, input logic [31:0] ad);
        return (sz > 3'd2) || (sz == 3'd1 && ad[0]) || (sz == 3'd2 && ad[1:0] != 2'b00)
               || (ad >= 32'(4 * DEPTH));
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [31:0] ad);
        case (sz)
            3'd0:    return 4'b0001 << ad[1:0];
            3'd1:    return ad[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic sb_t idle_item();
        sb_t it;
        it.resp = 2'b00; it.waits = 0; it.rd = 1'b0; it.rdata = 32'd0; it.wdata = 32'd0;
        return it;
    endfunction

    // Offer one address phase (vld=0 for IDLE) and finish the previous data phase.
    task automatic issue(input bit vld, input bit wr, input logic [2:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd, input bit scribble);
        sb_t it;
        sb_t cur;
        bit  er;
        bit  done;
        int  waits;
        int  idx;
        logic [3:0] ln;
        er       = vld && is_err(sz, ad);
        it       = idle_item();
        it.wdata = wd;
        if (vld) begin
            it.resp  = er ? 2'b01 : 2'b00;
            it.waits = er ? 1 : (dsel ? 2 : 0);
            if (!er) begin
                idx = int'(ad[5:2]);
                if (wr) begin
                    ln = lanes(sz, ad);
                    for (int i = 0; i < 4; i++)
                        if (ln[i]) mm[dsel][idx][8*i +: 8] = wd[8*i +: 8];
                end else begin
                    it.rd    = 1'b1;
                    it.rdata = mm[dsel][idx];
                end
            end
        end
        sbq.push_back(it);
        b_trans = vld ? 2'b10 : 2'b00;
        b_addr  = ad;
        b_write = wr;
        b_size  = sz;
        waits   = 0;
        done    = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge HCLK);
            cur = sbq[0];
            if (!m_ready) begin
                waits++;
                check_eq("wait_hresp", 32'(m_resp), 32'(cur.resp));
                check_eq("wait_hrdata_hold", m_rdata, m_hrdata[dsel]);
                if (scribble) b_wdata = $urandom;
            end else begin
                b_wdata = cur.wdata;
                check_eq("hresp", 32'(m_resp), 32'(cur.resp));
                check_eq("wait_cycles", 32'(waits), 32'(cur.waits));
                if (cur.rd) m_hrdata[dsel] = cur.rdata;
                check_eq("hrdata", m_rdata, m_hrdata[dsel]);
                void'(sbq.pop_front());
                done = 1'b1;
            end
            @(posedge HCLK);
            #1;
        end
        if (!done) check_eq("timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 3'd2, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        m_hrdata[0] = 32'd0;
        m_hrdata[1] = 32'd0;
        sbq.push_back(idle_item());
        repeat (3) @(posedge HCLK);
        #1;
        HRESET_n = 1'b1;

        // Zero-wait slave: reset values, bypass, lane merge, illegal transfers.
        idle(3);
        issue(1, 1, 3'd2, 32'h20, 32'h0000_0000, 0);
        issue(1, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0);
        issue(1, 0, 3'd2, 32'h10, 32'd0, 0);
        issue(1, 1, 3'd0, 32'h21, 32'h0000_AA00, 0);
        issue(1, 1, 3'd1, 32'h22, 32'h1234_0000, 0);
        issue(1, 0, 3'd2, 32'h20, 32'd0, 0);
        issue(1, 1, 3'd2, 32'h00, 32'h1111_1111, 0);
        issue(1, 1, 3'd2, 32'h04, 32'h2222_2222, 0);
        issue(1, 1, 3'd2, 32'h02, 32'hFFFF_FFFF, 0);
        issue(1, 1, 3'd3, 32'h04, 32'hFFFF_FFFF, 0);
        issue(1, 1, 3'd2, 32'h40, 32'hFFFF_FFFF, 0);
        issue(1, 0, 3'd2, 32'h40, 32'd0, 0);
        issue(1, 1, 3'd1, 32'h05, 32'hFFFF_FFFF, 0);
        issue(1, 0, 3'd2, 32'h00, 32'd0, 0);
        issue(1, 0, 3'd2, 32'h04, 32'd0, 0);
        issue(1, 0, 3'd2, 32'h20, 32'd0, 0);
        idle(2);

        // Two-wait-state slave.
        dsel = 1'b1;
        idle(2);
        issue(1, 1, 3'd2, 32'h30, 32'h5A5A_5A5A, 1);
        issue(1, 1, 3'd2, 32'h34, 32'h0F0F_0F0F, 1);
        issue(1, 0, 3'd2, 32'h30, 32'd0, 0);
        issue(1, 0, 3'd2, 32'h34, 32'd0, 0);
        issue(1, 1, 3'd2, 32'h02, 32'hFFFF_FFFF, 0);
        issue(1, 0, 3'd2, 32'h40, 32'd0, 0);
        issue(1, 0, 3'd2, 32'h30, 32'd0, 0);
        idle(2);

        // Reset during the second wait cycle of a write to 0x30.
        b_trans = 2'b10; b_write = 1'b1; b_size = 3'd2; b_addr = 32'h30;
        @(negedge HCLK);
        check_eq("rst_seq_ready0", 32'(m_ready), 32'd1);
        @(posedge HCLK); #1;
        b_trans = 2'b00;
        @(negedge HCLK);
        b_wdata = 32'hBAD0_BAD0;
        check_eq("rst_seq_wait1", 32'(m_ready), 32'd0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check_eq("rst_seq_wait2", 32'(m_ready), 32'd0);
        HRESET_n = 1'b0;
        @(posedge HCLK); #1;
        HRESET_n = 1'b1;
        @(negedge HCLK);
        check_eq("rst_hreadyout", 32'(m_ready), 32'd1);
        check_eq("rst_hresp", 32'(m_resp), 32'd0);
        check_eq("rst_hrdata", m_rdata, 32'd0);
        check_eq("rst_hrdata_dut0", bus0.HRDATA, 32'd0);
        @(posedge HCLK); #1;
        sbq.delete();
        sbq.push_back(idle_item());
        m_hrdata[0] = 32'd0;
        m_hrdata[1] = 32'd0;
        issue(1, 0, 3'd2, 32'h30, 32'd0, 0);
        issue(1, 1, 3'd0, 32'h35, 32'h0000_7700, 1);
        issue(1, 0, 3'd2, 32'h34, 32'd0, 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
